// File: rtl/param_shift_pkg.sv
// Shared operation encodings for the parametrised shift register.
package param_shift_pkg;

  // Operation selected by the mode port when shift_en is high.
  typedef enum logic [1:0] {
    MODE_FWD  = 2'b00,
    MODE_REV  = 2'b01,
    MODE_ROT  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage : param_shift_pkg

// File: rtl/shift_stage_cell.sv
// One shift-register stage: WIDTH data bits plus a valid bit, with a
// next-state mux choosing left neighbour, right neighbour, load slice or hold.
module shift_stage_cell
  import param_shift_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] left_data,
  input  logic             left_valid,
  input  logic [WIDTH-1:0] right_data,
  input  logic             right_valid,
  input  logic [WIDTH-1:0] load_slice,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_next;
  logic             valid_next;

  // Select the value this stage samples at the next edge.
  always_comb begin
    data_next  = data;
    valid_next = valid;
    if (en) begin
      unique case (mode)
        MODE_FWD, MODE_ROT: begin
          data_next  = left_data;
          valid_next = left_valid;
        end
        MODE_REV: begin
          data_next  = right_data;
          valid_next = right_valid;
        end
        MODE_LOAD: begin
          data_next  = load_slice;
          valid_next = 1'b1;
        end
        default: begin
          data_next  = data;
          valid_next = valid;
        end
      endcase
    end
  end

  // Stage register; reset clears both data and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      data  <= data_next;
      valid <= valid_next;
    end
  end

endmodule : shift_stage_cell

// File: rtl/param_shift_reg.sv
// DEPTH-stage, WIDTH-bit multi-mode shift register (forward, reverse,
// rotate, parallel load) with per-stage valid tracking.
module param_shift_reg
  import param_shift_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       d,
  input  logic                   shift_en,
  input  logic [1:0]             mode,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  output logic [WIDTH-1:0]       dout,
  output logic [WIDTH-1:0]       dout_lo,
  output logic                   dout_valid,
  output logic [WIDTH*DEPTH-1:0] q_all,
  output logic [CNT_W-1:0]       fill_count,
  output logic                   full
);

  mode_t                       op;
  logic [DEPTH-1:0][WIDTH-1:0] s;
  logic [DEPTH-1:0]            v;

  assign op = mode_t'(mode);

  // Chain of stages; open ends take d (valid 1), stage 0 wraps from the top on ROT.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] left_data;
    logic             left_valid;
    logic [WIDTH-1:0] right_data;
    logic             right_valid;

    if (gi == 0) begin : g_left_end
      assign left_data  = (op == MODE_ROT) ? s[DEPTH-1] : d;
      assign left_valid = (op == MODE_ROT) ? v[DEPTH-1] : 1'b1;
    end else begin : g_left_mid
      assign left_data  = s[gi-1];
      assign left_valid = v[gi-1];
    end

    if (gi == DEPTH - 1) begin : g_right_end
      assign right_data  = d;
      assign right_valid = 1'b1;
    end else begin : g_right_mid
      assign right_data  = s[gi+1];
      assign right_valid = v[gi+1];
    end

    shift_stage_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk        (clk),
      .reset      (reset),
      .en         (shift_en),
      .mode       (op),
      .left_data  (left_data),
      .left_valid (left_valid),
      .right_data (right_data),
      .right_valid(right_valid),
      .load_slice (load_data[gi*WIDTH +: WIDTH]),
      .data       (s[gi]),
      .valid      (v[gi])
    );
  end

  // Occupancy: number of stages currently holding valid data.
  always_comb begin
    fill_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fill_count = fill_count + CNT_W'(v[i]);
    end
  end

  assign full       = &v;
  assign dout       = s[DEPTH-1];
  assign dout_lo    = s[0];
  assign dout_valid = v[DEPTH-1];
  assign q_all      = s;

endmodule : param_shift_reg

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
Parametrised, multi-mode successor to the single-bit serial shift register. It is a DEPTH-stage chain of WIDTH-bit stages with four operations: forward shift, reverse shift, rotate and parallel load. Per-stage valid tracking drives occupancy and full flags. All updates use nonblocking semantics so each stage samples the pre-edge value of its neighbour. The block is the generic delay line and serialiser used by the datapath and demo benches.

Parameters:
WIDTH, 1, bits per stage (>=1)
DEPTH, 4, number of stages (>=1)
CNT_W, $clog2(DEPTH+1), width of fill_count (derived; not overridden)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
d  in  WIDTH  serial data in
shift_en  in  1  operation enable; 0 = hold all state
mode  in  2  00 FWD, 01 REV, 10 ROT, 11 LOAD
load_data  in  WIDTH*DEPTH  parallel load; stage i = load_data[i*WIDTH +: WIDTH]
dout  out  WIDTH  s[DEPTH-1] (forward serial out)
dout_lo  out  WIDTH  s[0] (reverse serial out)
dout_valid  out  1  v[DEPTH-1]
q_all  out  WIDTH*DEPTH  all stages, same packing as load_data
fill_count  out  CNT_W  popcount of v[]
full  out  1  all v[] = 1

Behaviour:
- State: data stages s[0..DEPTH-1] and valid bits v[0..DEPTH-1]. All outputs are direct decodes of registered state; there is no combinational path from inputs to outputs.
- Priority, per rising edge: reset, then shift_en=0 (hold), then mode.
- reset=1: every s[i]=0 and every v[i]=0. Therefore dout, dout_lo, q_all, fill_count, dout_valid and full are all 0 after that edge. d, mode and shift_en are ignored that cycle.
- FWD: s[0]<=d, s[i]<=s[i-1]; v[0]<=1, v[i]<=v[i-1].
- REV: s[DEPTH-1]<=d, s[i]<=s[i+1]; v[DEPTH-1]<=1, v[i]<=v[i+1].
- ROT (forward rotate): s[0]<=s[DEPTH-1], s[i]<=s[i-1]; v rotates identically. Data and v are conserved.
- LOAD: s[i]<=load_data slice i; all v<=1.
- Latency: d sampled at enabled FWD edge N appears on dout after edge N+DEPTH-1. With DEPTH=1 it appears after edge N.
- Fill: starting from empty with continuous FWD, fill_count steps 1..DEPTH. full and dout_valid rise after exactly DEPTH enabled edges. Once full, further FWD/REV keeps fill_count=DEPTH with no wrap or overflow.
- DEPTH=1: FWD, REV and ROT-with-d are degenerate. ROT holds s[0]. dout=dout_lo.
- Reset mid-operation: takes effect at the next edge regardless of shift_en or mode. Refill restarts from empty.
- The register chain is strictly edge-sampled. A forward shift never propagates d through more than one stage per edge; this is the failure mode of the earlier bad variants and must be explicitly checked.

Decomposition:
- Shared package param_shift_pkg: MODE_FWD=2'b00, MODE_REV=2'b01, MODE_ROT=2'b10, MODE_LOAD=2'b11, plus the mode_t typedef.
- Sub-module shift_stage_cell: one WIDTH+1-bit register (data plus valid) with a 4:1 next-state mux (left neighbour, right neighbour, load slice, hold) and synchronous reset. It is instantiated DEPTH times in a generate loop. End cells take d (data) or 1 (valid) at the open boundaries and wrap for ROT.
- The top level contains only neighbour wiring, popcount and full.

Test Plan:
1. WIDTH=8, DEPTH=4. Hold reset 3 cycles with shift_en=1, d=8'hAA -> q_all=0, dout=0, dout_lo=0, fill_count=0, full=0, dout_valid=0.
2. FWD, d=11,22,33,44 on 4 consecutive edges -> s3..s0=11,22,33,44; dout=8'h11; fill_count=4; full=1. dout_valid=0 after edge 3 and 1 after edge 4. After edge 1 only s[0]=11 (no fall-through).
3. From scenario 2, shift_en=0 for 5 cycles with random mode, d and load_data -> q_all unchanged, fill_count=4.
4. From scenario 2, one ROT -> s3..s0=22,33,44,11, dout=8'h22. Four ROTs total -> original state restored.
5. LOAD with load_data=32'hDEADBEEF -> s3..s0=DE,AD,BE,EF, full=1. Then one REV with d=8'h5A -> s3..s0=5A,DE,AD,BE; dout_lo=8'hBE; dout=8'h5A.
6. After 2 FWD edges (fill_count=2), assert reset for 1 cycle with shift_en=1 -> all zero next edge. Then continuous FWD -> dout_valid rises after exactly 4 enabled edges and fill_count steps 1,2,3,4.
